// File: rtl/vote_session_ctrl.sv
// Round sequencer for a three-input majority voter: collects one ballot per
// requester, defaults missing ballots on timeout, captures and holds the decision.
module vote_session_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ballot_valid,
    input  logic [2:0]       ballot_val,
    output logic [2:0]       ballot_ack,
    output logic             voter_a,
    output logic             voter_b,
    output logic             voter_c,
    input  logic             voter_result,
    output logic             busy,
    output logic             result,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             timed_out,
    output logic [CNT_W-1:0] round_cnt,
    output logic [CNT_W-1:0] pass_cnt
);

    localparam int unsigned      TMR_W    = 8;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EVAL    = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         ballot_q, ballot_d;
    logic [2:0]         submitted_q, submitted_d;
    logic [2:0]         ack_q, ack_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               timed_out_q, timed_out_d;
    logic               result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   round_q, round_d;
    logic [CNT_W-1:0]   pass_q, pass_d;

    logic [2:0]         accept_c;
    logic               all_in_c;

    // Only first-time ballots in COLLECT are accepted; repeats are dropped.
    assign accept_c = (state_q == S_COLLECT) ? (ballot_valid & ~submitted_q) : 3'b000;
    assign all_in_c = &(submitted_q | accept_c);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_COLLECT;
            S_COLLECT: if (all_in_c || (timer_q == TMR_LAST)) state_d = S_EVAL;
            S_EVAL:    state_d = S_DONE;
            S_DONE:    if (result_ack) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ballot_d       = ballot_q;
        submitted_d    = submitted_q;
        ack_d          = 3'b000;
        timer_d        = timer_q;
        timed_out_d    = timed_out_q;
        result_d       = result_q;
        round_d        = round_q;
        pass_d         = pass_q;
        busy_d         = (state_d != S_IDLE);
        result_valid_d = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ballot_d    = 3'b000;
                    submitted_d = 3'b000;
                    timer_d     = '0;
                    timed_out_d = 1'b0;
                end
            end
            S_COLLECT: begin
                ballot_d    = (ballot_q & ~accept_c) | (ballot_val & accept_c);
                submitted_d = submitted_q | accept_c;
                ack_d       = accept_c;
                timer_d     = timer_q + TMR_W'(1);
                if ((state_d == S_EVAL) && !all_in_c) timed_out_d = 1'b1;
            end
            S_EVAL: begin
                result_d = voter_result;
                round_d  = round_q + CNT_W'(1);
                pass_d   = pass_q + CNT_W'(voter_result);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ballot_q       <= 3'b000;
            submitted_q    <= 3'b000;
            ack_q          <= 3'b000;
            timer_q        <= '0;
            timed_out_q    <= 1'b0;
            result_q       <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            round_q        <= '0;
            pass_q         <= '0;
        end else begin
            ballot_q       <= ballot_d;
            submitted_q    <= submitted_d;
            ack_q          <= ack_d;
            timer_q        <= timer_d;
            timed_out_q    <= timed_out_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            round_q        <= round_d;
            pass_q         <= pass_d;
        end
    end

    assign ballot_ack   = ack_q;
    assign voter_a      = ballot_q[0];
    assign voter_b      = ballot_q[1];
    assign voter_c      = ballot_q[2];
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timed_out    = timed_out_q;
    assign round_cnt    = round_q;
    assign pass_cnt     = pass_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl with a behavioural majority voter.
module tb_vote_session_ctrl;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [2:0]       ballot_valid;
    logic [2:0]       ballot_val;
    logic [2:0]       ballot_ack;
    logic             voter_a, voter_b, voter_c;
    logic             voter_result;
    logic             busy, result, result_valid, result_ack, timed_out;
    logic [CNT_W-1:0] round_cnt, pass_cnt;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    assign voter_result = (voter_a & voter_b) | (voter_a & voter_c) | (voter_b & voter_c);

    vote_session_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ballot_valid (ballot_valid),
        .ballot_val   (ballot_val),
        .ballot_ack   (ballot_ack),
        .voter_a      (voter_a),
        .voter_b      (voter_b),
        .voter_c      (voter_c),
        .voter_result (voter_result),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .timed_out    (timed_out),
        .round_cnt    (round_cnt),
        .pass_cnt     (pass_cnt)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_done(input string tag, input int unsigned res, input int unsigned to,
                              input int unsigned rnd, input int unsigned pas);
        check({tag, ".rv"},    32'(result_valid), 1);
        check({tag, ".res"},   32'(result), res);
        check({tag, ".to"},    32'(timed_out), to);
        check({tag, ".round"}, 32'(round_cnt), rnd);
        check({tag, ".pass"},  32'(pass_cnt), pas);
    endtask

    task automatic release_done(input string tag);
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        check({tag, ".rel_rv"},   32'(result_valid), 0);
        check({tag, ".rel_busy"}, 32'(busy), 0);
    endtask

    task automatic quick_round(input string tag, input int unsigned rnd, input int unsigned pas);
        start = 1'b1;
        step();
        start = 1'b0;
        ballot_valid = 3'b111;
        ballot_val   = 3'b111;
        step();
        ballot_valid = 3'b000;
        check({tag, ".ack"}, 32'(ballot_ack), 7);
        step();
        check_done(tag, 1, 0, rnd, pas);
        release_done(tag);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ballot_valid = 3'b000; ballot_val = 3'b000; result_ack = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst.busy",  32'(busy), 0);
        check("rst.rv",    32'(result_valid), 0);
        check("rst.round", 32'(round_cnt), 0);
        check("rst.pass",  32'(pass_cnt), 0);
        check("rst.voter", 32'({voter_c, voter_b, voter_a}), 0);

        // Ballots in IDLE are ignored.
        ballot_valid = 3'b111; ballot_val = 3'b111;
        step();
        check("idle.ack",  32'(ballot_ack), 0);
        check("idle.busy", 32'(busy), 0);
        ballot_valid = 3'b000;

        // 1: all three in first COLLECT cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1.busy", 32'(busy), 1);
        ballot_valid = 3'b111; ballot_val = 3'b011;
        step();
        ballot_valid = 3'b000;
        check("t1.ack", 32'(ballot_ack), 7);
        check("t1.rv_eval", 32'(result_valid), 0);
        step();
        check("t1.ack_gone", 32'(ballot_ack), 0);
        check_done("t1", 1, 0, 1, 1);
        release_done("t1");
        check("t1.res_hold", 32'(result), 1);

        // 2: separate acceptances, repeat valid from C ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        ballot_valid = 3'b100; ballot_val = 3'b000;
        step();
        check("t2.ack_c", 32'(ballot_ack), 4);
        ballot_valid = 3'b101; ballot_val = 3'b101;
        step();
        check("t2.ack_a_only", 32'(ballot_ack), 1);
        check("t2.voter_c", 32'(voter_c), 0);
        ballot_valid = 3'b010; ballot_val = 3'b000;
        step();
        ballot_valid = 3'b000;
        check("t2.ack_b", 32'(ballot_ack), 2);
        step();
        check_done("t2", 0, 0, 2, 1);
        release_done("t2");

        // 3a: only A submits; COLLECT lasts exactly TIMEOUT cycles.
        start = 1'b1;
        step();
        start = 1'b0;
        ballot_valid = 3'b001; ballot_val = 3'b001;
        step();
        ballot_valid = 3'b000;
        for (int i = 0; i < 15; i++) step();
        check("t3a.rv_eval", 32'(result_valid), 0);
        step();
        check_done("t3a", 0, 1, 3, 1);
        release_done("t3a");

        // 3b: A and B submit, C times out; round counter wraps to 0.
        start = 1'b1;
        step();
        start = 1'b0;
        ballot_valid = 3'b011; ballot_val = 3'b011;
        step();
        ballot_valid = 3'b000;
        for (int i = 0; i < 15; i++) step();
        check("t3b.rv_eval", 32'(result_valid), 0);
        step();
        check_done("t3b", 1, 1, 0, 2);
        release_done("t3b");

        // 4: last ballot lands in the final COLLECT cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        ballot_valid = 3'b011; ballot_val = 3'b001;
        step();
        ballot_valid = 3'b000;
        for (int i = 0; i < 14; i++) step();
        ballot_valid = 3'b100; ballot_val = 3'b100;
        step();
        ballot_valid = 3'b000;
        check("t4.ack_last", 32'(ballot_ack), 4);
        check("t4.rv_eval", 32'(result_valid), 0);
        step();
        check_done("t4", 1, 0, 1, 3);
        release_done("t4");

        // 5: start ignored in COLLECT/DONE; DONE holds until acknowledged.
        start = 1'b1;
        step();
        ballot_valid = 3'b111; ballot_val = 3'b000;
        step();
        ballot_valid = 3'b000;
        start = 1'b0;
        step();
        check_done("t5", 0, 0, 2, 3);
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            step();
        end
        check("t5.rv_held", 32'(result_valid), 1);
        check("t5.busy_held", 32'(busy), 1);
        start = 1'b1;
        release_done("t5");
        start = 1'b0;
        step();
        check("t5.no_queue", 32'(busy), 0);
        quick_round("t5n", 3, 0);

        // 6: synchronous reset mid-COLLECT, then counter wrap with CNT_W=2.
        start = 1'b1;
        step();
        start = 1'b0;
        ballot_valid = 3'b001; ballot_val = 3'b001;
        step();
        ballot_valid = 3'b000;
        check("t6.pre_voter_a", 32'(voter_a), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6.busy",  32'(busy), 0);
        check("t6.ack",   32'(ballot_ack), 0);
        check("t6.voter", 32'({voter_c, voter_b, voter_a}), 0);
        check("t6.res",   32'(result), 0);
        check("t6.rv",    32'(result_valid), 0);
        check("t6.to",    32'(timed_out), 0);
        check("t6.round", 32'(round_cnt), 0);
        check("t6.pass",  32'(pass_cnt), 0);
        for (int r = 1; r <= 5; r++) quick_round("t6w", r % 4, r % 4);
        check("t6.round_wrap", 32'(round_cnt), 1);
        check("t6.pass_wrap",  32'(pass_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
